// File: rtl/add_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module : add_sub_pkg
// Brief  : Shared constants and full-adder helpers for the add_sub datapath.
// Rev    : 1.0
// ============================================================================
package add_sub_pkg;

    localparam int   ADD_SUB_WIDTH = 4;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic logic fa_sum(input logic x, input logic y, input logic ci);
        return x ^ y ^ ci;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic ci);
        return (x & y) | (ci & (x ^ y));
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_sub_rca.sv
`default_nettype none
// ============================================================================
// Module : add_sub_rca
// Brief  : Combinational WIDTH-bit ripple-carry adder of full-adder cells.
// Rev    : 1.0
// ============================================================================
module add_sub_rca
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] bx,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic [WIDTH:0] w_carry;

    assign w_carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]       = fa_sum(a[i], bx[i], w_carry[i]);
        assign w_carry[i+1] = fa_carry(a[i], bx[i], w_carry[i]);
    end

    assign cout    = w_carry[WIDTH];
    // Carry into the MSB; XOR with cout gives signed overflow.
    assign msb_cin = w_carry[WIDTH-1];

endmodule
`default_nettype wire

// File: rtl/add_sub.sv
`default_nettype none
// ============================================================================
// Module : add_sub
// Brief  : Registered two's-complement adder/subtractor, 1-cycle latency.
//          Define ADD_SUB_FLAGS_EN to add registered overflow/zero outputs.
// Rev    : 1.0
// ============================================================================
module add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = ADD_SUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             in_valid,
    output logic [WIDTH-1:0] res,
    output logic             carry,
`ifdef ADD_SUB_FLAGS_EN
    output logic             overflow,
    output logic             zero,
`endif
    output logic             out_valid
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_msb_cin;

    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_out_valid;

    // c_in doubles as the adder carry-in, so subtract is a + ~b + 1.
    assign w_bx = b ^ {WIDTH{c_in == MODE_SUB}};

    add_sub_rca #(
        .WIDTH   (WIDTH)
    ) u_rca (
        .a       (a),
        .bx      (w_bx),
        .cin     (c_in),
        .sum     (w_sum),
        .cout    (w_cout),
        .msb_cin (w_msb_cin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_res   <= w_sum;
                r_carry <= w_cout;
            end
        end
    end

    assign res       = r_res;
    assign carry     = r_carry;
    assign out_valid = r_out_valid;

`ifdef ADD_SUB_FLAGS_EN
    logic r_overflow;
    logic r_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (in_valid) begin
            r_overflow <= w_msb_cin ^ w_cout;
            r_zero     <= (w_sum == '0);
        end
    end

    assign overflow = r_overflow;
    assign zero     = r_zero;
`else
    logic w_unused;
    assign w_unused = w_msb_cin;
`endif

endmodule
`default_nettype wire

// File: tb/tb_add_sub.sv
`default_nettype none
// ============================================================================
// Module : tb_add_sub
// Brief  : Self-checking scoreboard bench for add_sub (WIDTH = 4).
// Rev    : 1.0
// ============================================================================
module tb_add_sub;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
        logic         zero;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         in_valid;
    logic [W-1:0] res;
    logic         carry;
    logic         out_valid;
`ifdef ADD_SUB_FLAGS_EN
    logic         overflow;
    logic         zero;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t held;

    add_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .in_valid  (in_valid),
        .res       (res),
        .carry     (carry),
`ifdef ADD_SUB_FLAGS_EN
        .overflow  (overflow),
        .zero      (zero),
`endif
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        exp_t e;
        int   ux = int'(x);
        int   uy = int'(y);
        int   sx = $signed(x);
        int   sy = $signed(y);
        int   u;
        int   s;
        if (!sub) begin
            u       = ux + uy;
            s       = sx + sy;
            e.carry = (u >= (1 << W));
        end else begin
            u       = ux - uy + (1 << W);
            s       = sx - sy;
            e.carry = (ux >= uy);
        end
        e.res  = W'(u % (1 << W));
        e.ovf  = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
        e.zero = (e.res == '0);
        return e;
    endfunction

    // Drive one cycle of stimulus, then check what the DUT shows after the edge.
    task automatic step(input logic r, input logic v, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic sub);
        exp_t e;
        rst      = r;
        in_valid = v;
        a        = x;
        b        = y;
        c_in     = sub;
        if (v && !r) sb.push_back(model(x, y, sub));
        @(posedge clk);
        #1;
        if (r) begin
            sb.delete();
            held = '0;
            check("rst_res",   32'(res),       32'(0));
            check("rst_carry", 32'(carry),     32'(0));
            check("rst_valid", 32'(out_valid), 32'(0));
`ifdef ADD_SUB_FLAGS_EN
            check("rst_ovf",   32'(overflow),  32'(0));
            check("rst_zero",  32'(zero),      32'(0));
`endif
        end else if (v) begin
            check("out_valid", 32'(out_valid), 32'(1));
            if (sb.size() == 0) begin
                check("sb_empty", 32'(1), 32'(0) + 32'(out_valid == 1'b0));
            end else begin
                e    = sb.pop_front();
                held = e;
                check("res",   32'(res),   32'(e.res));
                check("carry", 32'(carry), 32'(e.carry));
`ifdef ADD_SUB_FLAGS_EN
                check("overflow", 32'(overflow), 32'(e.ovf));
                check("zero",     32'(zero),     32'(e.zero));
`endif
            end
        end else begin
            check("idle_valid", 32'(out_valid), 32'(0));
            check("hold_res",   32'(res),       32'(held.res));
            check("hold_carry", 32'(carry),     32'(held.carry));
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
        held = '0;

        // Reset wins over a simultaneous valid operation.
        step(1'b1, 1'b1, 4'b1111, 4'b1111, 1'b0);

        step(1'b0, 1'b1, 4'b0011, 4'b0011, 1'b0);
        step(1'b0, 1'b1, 4'b1010, 4'b0011, 1'b0);
        step(1'b0, 1'b1, 4'b1111, 4'b0101, 1'b0);
        step(1'b0, 1'b1, 4'b1100, 4'b1001, 1'b1);
        step(1'b0, 1'b1, 4'b1100, 4'b1110, 1'b1);

        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 4'(i * 5 + 1), 4'(i * 3 + 7), 1'(i));

        step(1'b0, 1'b1, 4'b1111, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0000, 4'b0001, 1'b1);
        step(1'b0, 1'b1, 4'b0110, 4'b0110, 1'b1);
        step(1'b0, 1'b1, 4'b0111, 4'b0001, 1'b0);
        step(1'b0, 1'b1, 4'b0101, 4'b0101, 1'b1);
        step(1'b0, 1'b1, 4'b1000, 4'b0001, 1'b1);

        // Reset mid-stream discards the pending result.
        step(1'b0, 1'b1, 4'b1001, 4'b0010, 1'b0);
        step(1'b1, 1'b1, 4'b1110, 4'b0011, 1'b1);
        step(1'b0, 1'b0, 4'b1010, 4'b0101, 1'b0);

        for (int i = 0; i < 60; i++)
            step(1'b0, 1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                 1'($urandom));

        check("sb_drained", 32'(sb.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
